// File: rtl/axi_addr_router.sv
// 1-master to SLV_NUM-slave AXI4 address router with an internal DECERR responder.
// Optional decode-error counter port err_cnt when AXI_ROUTER_ERRCNT_EN is defined.
module axi_addr_router #(
  parameter int unsigned SLV_NUM = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_START = {32'h8000_0000, 32'h1000_0000},
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_END   = {32'h9000_0000, 32'h1000_1000}
) (
  input  logic                        clk,
  input  logic                        rst,
  // master write address
  input  logic [ADDR_W-1:0]           m_awaddr,
  input  logic [ID_W-1:0]             m_awid,
  input  logic [7:0]                  m_awlen,
  input  logic [2:0]                  m_awsize,
  input  logic [1:0]                  m_awburst,
  input  logic                        m_awvalid,
  output logic                        m_awready,
  // master write data
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W/8-1:0]         m_wstrb,
  input  logic                        m_wlast,
  input  logic                        m_wvalid,
  output logic                        m_wready,
  // master write response
  output logic [ID_W-1:0]             m_bid,
  output logic [1:0]                  m_bresp,
  output logic                        m_bvalid,
  input  logic                        m_bready,
  // master read address
  input  logic [ADDR_W-1:0]           m_araddr,
  input  logic [ID_W-1:0]             m_arid,
  input  logic [7:0]                  m_arlen,
  input  logic [2:0]                  m_arsize,
  input  logic [1:0]                  m_arburst,
  input  logic                        m_arvalid,
  output logic                        m_arready,
  // master read data
  output logic [ID_W-1:0]             m_rid,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        m_rvalid,
  input  logic                        m_rready,
  // slave write address
  output logic [SLV_NUM*ADDR_W-1:0]   s_awaddr,
  output logic [SLV_NUM*ID_W-1:0]     s_awid,
  output logic [SLV_NUM*8-1:0]        s_awlen,
  output logic [SLV_NUM*3-1:0]        s_awsize,
  output logic [SLV_NUM*2-1:0]        s_awburst,
  output logic [SLV_NUM-1:0]          s_awvalid,
  input  logic [SLV_NUM-1:0]          s_awready,
  // slave write data
  output logic [SLV_NUM*DATA_W-1:0]   s_wdata,
  output logic [SLV_NUM*DATA_W/8-1:0] s_wstrb,
  output logic [SLV_NUM-1:0]          s_wlast,
  output logic [SLV_NUM-1:0]          s_wvalid,
  input  logic [SLV_NUM-1:0]          s_wready,
  // slave write response
  input  logic [SLV_NUM*ID_W-1:0]     s_bid,
  input  logic [SLV_NUM*2-1:0]        s_bresp,
  input  logic [SLV_NUM-1:0]          s_bvalid,
  output logic [SLV_NUM-1:0]          s_bready,
  // slave read address
  output logic [SLV_NUM*ADDR_W-1:0]   s_araddr,
  output logic [SLV_NUM*ID_W-1:0]     s_arid,
  output logic [SLV_NUM*8-1:0]        s_arlen,
  output logic [SLV_NUM*3-1:0]        s_arsize,
  output logic [SLV_NUM*2-1:0]        s_arburst,
  output logic [SLV_NUM-1:0]          s_arvalid,
  input  logic [SLV_NUM-1:0]          s_arready,
  // slave read data
  input  logic [SLV_NUM*ID_W-1:0]     s_rid,
  input  logic [SLV_NUM*DATA_W-1:0]   s_rdata,
  input  logic [SLV_NUM*2-1:0]        s_rresp,
  input  logic [SLV_NUM-1:0]          s_rlast,
  input  logic [SLV_NUM-1:0]          s_rvalid,
  output logic [SLV_NUM-1:0]          s_rready
`ifdef AXI_ROUTER_ERRCNT_EN
  ,
  output logic [15:0]                 err_cnt
`endif
);

  // Target index SLV_NUM denotes the internal error responder.
  localparam int unsigned TW = $clog2(SLV_NUM + 1);
  localparam logic [TW-1:0] ERR_TGT = TW'(SLV_NUM);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t           r_wstate;
  rstate_t           r_rstate;
  logic [TW-1:0]     r_wtgt;
  logic [TW-1:0]     r_rtgt;
  logic [ID_W-1:0]   r_awid;
  logic [ID_W-1:0]   r_arid;
  logic [7:0]        r_arlen;
  logic [7:0]        r_beat;

  logic [TW-1:0]     w_aw_tgt;
  logic [TW-1:0]     w_ar_tgt;
  logic              w_aw_hs;
  logic              w_ar_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_r_hs;

  function automatic logic [TW-1:0] f_decode(input logic [ADDR_W-1:0] addr);
    logic [TW-1:0] tgt;
    logic          found;
    tgt   = ERR_TGT;
    found = 1'b0;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (!found && addr >= SLV_START[i*ADDR_W +: ADDR_W] &&
          addr < SLV_END[i*ADDR_W +: ADDR_W]) begin
        tgt   = TW'(i);
        found = 1'b1;
      end
    end
    return tgt;
  endfunction

  assign w_aw_tgt = f_decode(m_awaddr);
  assign w_ar_tgt = f_decode(m_araddr);

  // Request payloads are broadcast; only the valid is steered.
  assign s_awaddr  = {SLV_NUM{m_awaddr}};
  assign s_awid    = {SLV_NUM{m_awid}};
  assign s_awlen   = {SLV_NUM{m_awlen}};
  assign s_awsize  = {SLV_NUM{m_awsize}};
  assign s_awburst = {SLV_NUM{m_awburst}};
  assign s_wdata   = {SLV_NUM{m_wdata}};
  assign s_wstrb   = {SLV_NUM{m_wstrb}};
  assign s_wlast   = {SLV_NUM{m_wlast}};
  assign s_araddr  = {SLV_NUM{m_araddr}};
  assign s_arid    = {SLV_NUM{m_arid}};
  assign s_arlen   = {SLV_NUM{m_arlen}};
  assign s_arsize  = {SLV_NUM{m_arsize}};
  assign s_arburst = {SLV_NUM{m_arburst}};

  // Write path routing; everything is gated while reset is held.
  always_comb begin
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bid     = '0;
    m_bresp   = '0;
    if (rst) begin
      case (r_wstate)
        W_IDLE: begin
          m_awready = 1'b1;
          for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (w_aw_tgt == TW'(i)) begin
              s_awvalid[i] = m_awvalid;
              m_awready    = s_awready[i];
            end
          end
        end
        W_DATA: begin
          m_wready = 1'b1;
          for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (r_wtgt == TW'(i)) begin
              s_wvalid[i] = m_wvalid;
              m_wready    = s_wready[i];
            end
          end
        end
        W_RESP: begin
          m_bvalid = 1'b1;
          m_bid    = r_awid;
          m_bresp  = 2'b11;
          for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (r_wtgt == TW'(i)) begin
              m_bvalid    = s_bvalid[i];
              m_bid       = s_bid[i*ID_W +: ID_W];
              m_bresp     = s_bresp[i*2 +: 2];
              s_bready[i] = m_bready;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read path routing.
  always_comb begin
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    if (rst) begin
      case (r_rstate)
        R_IDLE: begin
          m_arready = 1'b1;
          for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (w_ar_tgt == TW'(i)) begin
              s_arvalid[i] = m_arvalid;
              m_arready    = s_arready[i];
            end
          end
        end
        R_DATA: begin
          m_rvalid = 1'b1;
          m_rid    = r_arid;
          m_rresp  = 2'b11;
          m_rlast  = (r_beat == r_arlen);
          for (int unsigned i = 0; i < SLV_NUM; i++) begin
            if (r_rtgt == TW'(i)) begin
              m_rvalid    = s_rvalid[i];
              m_rid       = s_rid[i*ID_W +: ID_W];
              m_rdata     = s_rdata[i*DATA_W +: DATA_W];
              m_rresp     = s_rresp[i*2 +: 2];
              m_rlast     = s_rlast[i];
              s_rready[i] = m_rready;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_aw_hs = (r_wstate == W_IDLE) && m_awvalid && m_awready;
  assign w_w_hs  = (r_wstate == W_DATA) && m_wvalid && m_wready;
  assign w_b_hs  = (r_wstate == W_RESP) && m_bvalid && m_bready;
  assign w_ar_hs = (r_rstate == R_IDLE) && m_arvalid && m_arready;
  assign w_r_hs  = (r_rstate == R_DATA) && m_rvalid && m_rready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_wtgt   <= '0;
      r_awid   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_wtgt   <= w_aw_tgt;
          r_awid   <= m_awid;
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_w_hs && m_wlast) r_wstate <= W_RESP;
        W_RESP: if (w_b_hs) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_rtgt   <= '0;
      r_arid   <= '0;
      r_arlen  <= '0;
      r_beat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_rtgt   <= w_ar_tgt;
          r_arid   <= m_arid;
          r_arlen  <= m_arlen;
          r_beat   <= '0;
          r_rstate <= R_DATA;
        end
        R_DATA: if (w_r_hs) begin
          if (m_rlast) r_rstate <= R_IDLE;
          else         r_beat   <= r_beat + 8'd1;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_ROUTER_ERRCNT_EN
  logic [15:0] r_err_cnt;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;

  assign w_err_inc = {1'b0, (w_aw_hs && (w_aw_tgt == ERR_TGT))} +
                     {1'b0, (w_ar_hs && (w_ar_tgt == ERR_TGT))};
  assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_err_cnt <= '0;
    else if (w_err_sum[16]) r_err_cnt <= '1;
    else                   r_err_cnt <= w_err_sum[15:0];
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: slave 0 at 0x1000_0000..0x1000_0FFF, slave 1 at 0x8000_0000..0x8FFF_FFFF.
module tb_axi_addr_router;

  logic        clk;
  logic        rst;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  m_awid, m_arid, m_bid, m_rid, m_wstrb;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rlast, m_rvalid, m_rready;

  logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awid, s_arid, s_bid, s_rid, s_wstrb;
  logic [15:0] s_awlen, s_arlen;
  logic [5:0]  s_awsize, s_arsize;
  logic [3:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [1:0]  s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [1:0]  s_bvalid, s_bready, s_arvalid, s_arready;
  logic [1:0]  s_rlast, s_rvalid, s_rready;
`ifdef AXI_ROUTER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axi_addr_router #(.SLV_NUM(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
`ifdef AXI_ROUTER_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = 3'd2; m_awburst = 2'd1; m_awvalid = 1'b0;
    m_wdata = '0; m_wstrb = 4'hF; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
    m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = 3'd2; m_arburst = 2'd1; m_arvalid = 1'b0;
    m_rready = 1'b0;
    s_awready = '0; s_wready = '0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
    s_arready = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0;

    // Reset state
    tick(); tick();
    chk("rst_awready", m_awready, 0);
    chk("rst_arready", m_arready, 0);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_rvalid", m_rvalid, 0);
`ifdef AXI_ROUTER_ERRCNT_EN
    chk("rst_errcnt", err_cnt, 0);
`endif
    rst = 1'b1;
    tick();

    // Write 0x1000_0010 len 3 to slave 0
    m_awaddr = 32'h1000_0010; m_awid = 4'h5; m_awlen = 8'd3; m_awvalid = 1'b1;
    s_awready = 2'b01;
    #1;
    chk("w1_s_awvalid", s_awvalid, 2'b01);
    chk("w1_awready", m_awready, 1);
    tick();
    m_awvalid = 1'b0; s_awready = '0; s_wready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m_wvalid = 1'b1; m_wdata = 32'hA000_0000 + k; m_wlast = (k == 3);
      #1;
      chk("w1_s_wvalid", s_wvalid, 2'b01);
      chk("w1_wready", m_wready, 1);
      chk("w1_s_wdata", s_wdata[31:0], 32'hA000_0000 + k);
      chk("w1_s_awvalid_quiet", s_awvalid, 2'b00);
      tick();
    end
    m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = '0;
    s_bvalid = 2'b01; s_bid = 8'h05; s_bresp = 4'b0000; m_bready = 1'b1;
    #1;
    chk("w1_bvalid", m_bvalid, 1);
    chk("w1_bid", m_bid, 4'h5);
    chk("w1_bresp", m_bresp, 2'b00);
    chk("w1_s_bready", s_bready, 2'b01);
    tick();
    s_bvalid = '0; m_bready = 1'b0;
    #1;
    chk("w1_bvalid_done", m_bvalid, 0);

    // Read 0x8000_0000 len 0, slave 1 stalls arready for 5 cycles
    m_araddr = 32'h8000_0000; m_arid = 4'h3; m_arlen = 8'd0; m_arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("r2_arready_stall", m_arready, 0);
      chk("r2_s_arvalid", s_arvalid, 2'b10);
      tick();
    end
    s_arready = 2'b10;
    #1;
    chk("r2_arready", m_arready, 1);
    tick();
    m_arvalid = 1'b0; s_arready = '0;
    s_rvalid = 2'b10; s_rid = 8'h30; s_rdata = 64'h0000_CAFE_0000_0000; s_rlast = 2'b10; s_rresp = '0;
    m_rready = 1'b1;
    #1;
    chk("r2_rvalid", m_rvalid, 1);
    chk("r2_rdata", m_rdata, 32'h0000_CAFE);
    chk("r2_rlast", m_rlast, 1);
    chk("r2_rid", m_rid, 4'h3);
    chk("r2_s_rready", s_rready, 2'b10);
    tick();
    s_rvalid = '0; s_rlast = '0;
    m_araddr = 32'h2000_0000;
    #1;
    chk("r2_idle_rvalid", m_rvalid, 0);
    chk("r2_idle_arready", m_arready, 1);

    // Unmapped read 0x2000_0000 len 7
    m_arid = 4'h9; m_arlen = 8'd7; m_arvalid = 1'b1;
    #1;
    chk("r3_arready", m_arready, 1);
    chk("r3_s_arvalid", s_arvalid, 2'b00);
    tick();
    m_arvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("r3_rvalid", m_rvalid, 1);
      chk("r3_rdata", m_rdata, 0);
      chk("r3_rresp", m_rresp, 2'b11);
      chk("r3_rid", m_rid, 4'h9);
      chk("r3_rlast", m_rlast, (k == 7));
      tick();
    end
    #1;
    chk("r3_rvalid_done", m_rvalid, 0);
`ifdef AXI_ROUTER_ERRCNT_EN
    chk("r3_errcnt", err_cnt, 1);
`endif
    m_rready = 1'b0;

    // Unmapped write 0x0 len 1 with B backpressure
    m_awaddr = 32'h0; m_awid = 4'hA; m_awlen = 8'd1; m_awvalid = 1'b1;
    #1;
    chk("w4_awready", m_awready, 1);
    chk("w4_s_awvalid", s_awvalid, 2'b00);
    tick();
    m_awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_wvalid = 1'b1; m_wlast = (k == 1); m_wdata = 32'hBEEF_0000 + k;
      #1;
      chk("w4_wready", m_wready, 1);
      chk("w4_s_wvalid", s_wvalid, 2'b00);
      tick();
    end
    m_wvalid = 1'b0; m_wlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("w4_bvalid_hold", m_bvalid, 1);
      chk("w4_bresp", m_bresp, 2'b11);
      chk("w4_bid", m_bid, 4'hA);
      tick();
    end
    m_bready = 1'b1;
    #1;
    chk("w4_bvalid", m_bvalid, 1);
    tick();
    m_bready = 1'b0;
    #1;
    chk("w4_bvalid_done", m_bvalid, 0);
`ifdef AXI_ROUTER_ERRCNT_EN
    chk("w4_errcnt", err_cnt, 2);
`endif

    // Concurrent read to slave 0 and write to slave 1
    m_araddr = 32'h1000_0100; m_arid = 4'h1; m_arlen = 8'd0; m_arvalid = 1'b1;
    m_awaddr = 32'h8000_0040; m_awid = 4'h2; m_awlen = 8'd0; m_awvalid = 1'b1;
    s_arready = 2'b01; s_awready = 2'b10;
    #1;
    chk("c5_s_arvalid", s_arvalid, 2'b01);
    chk("c5_s_awvalid", s_awvalid, 2'b10);
    chk("c5_arready", m_arready, 1);
    chk("c5_awready", m_awready, 1);
    tick();
    m_arvalid = 1'b0; m_awvalid = 1'b0; s_arready = '0; s_awready = '0;
    m_wvalid = 1'b1; m_wlast = 1'b1; m_wdata = 32'h55; s_wready = 2'b10;
    s_rvalid = 2'b01; s_rid = 8'h01; s_rdata = 64'h0000_0000_0000_0077; s_rlast = 2'b01; m_rready = 1'b1;
    #1;
    chk("c5_s_wvalid", s_wvalid, 2'b10);
    chk("c5_wready", m_wready, 1);
    chk("c5_rvalid", m_rvalid, 1);
    chk("c5_rdata", m_rdata, 32'h77);
    chk("c5_s_rready", s_rready, 2'b01);
    tick();
    m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = '0;
    s_rvalid = '0; s_rlast = '0;
    s_bvalid = 2'b11; s_bid = 8'h27; s_bresp = 4'b0010; m_bready = 1'b1;
    #1;
    chk("c5_bid", m_bid, 4'h2);
    chk("c5_bresp", m_bresp, 2'b00);
    chk("c5_s_bready", s_bready, 2'b10);
    chk("c5_rvalid_done", m_rvalid, 0);
    tick();
    s_bvalid = '0; m_bready = 1'b0; m_rready = 1'b0;

    // Reset asserted during beat 2 of a 4-beat read from slave 0
    m_araddr = 32'h1000_0000; m_arid = 4'h4; m_arlen = 8'd3; m_arvalid = 1'b1; s_arready = 2'b01;
    #1;
    chk("r6_arready", m_arready, 1);
    tick();
    m_arvalid = 1'b0; s_arready = '0;
    s_rvalid = 2'b01; s_rid = 8'h04; s_rdata = 64'h1; s_rlast = '0; m_rready = 1'b1;
    #1;
    chk("r6_beat1", m_rvalid, 1);
    tick();
    s_rdata = 64'h2;
    rst = 1'b0;
    #1;
    chk("r6_rst_rvalid", m_rvalid, 0);
    chk("r6_rst_s_rready", s_rready, 2'b00);
    chk("r6_rst_arready", m_arready, 0);
    chk("r6_rst_awready", m_awready, 0);
    tick();
    s_rvalid = '0;
    rst = 1'b1;
    tick();
`ifdef AXI_ROUTER_ERRCNT_EN
    chk("r6_errcnt", err_cnt, 0);
`endif
    m_arvalid = 1'b1; s_arready = 2'b01;
    #1;
    chk("r6_new_arready", m_arready, 1);
    chk("r6_new_s_arvalid", s_arvalid, 2'b01);
    tick();
    m_arvalid = 1'b0; s_arready = '0;
    s_rvalid = 2'b01; s_rlast = 2'b01; s_rdata = 64'h9;
    #1;
    chk("r6_new_rvalid", m_rvalid, 1);
    chk("r6_new_rdata", m_rdata, 32'h9);
    tick();
    s_rvalid = '0; s_rlast = '0; m_rready = 1'b0;
    #1;
    chk("r6_final_rvalid", m_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
